risc16_sequencer: RTL and testbench

Multi-cycle control sequencer for the non-pipelined RiSC-16 core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB states and drives the enables and selects for the PC, instruction register, register file, ALU and data memory. It stalls on instruction-memory and data-memory ready handshakes and keeps a retired-instruction counter. It sits inside `control` beside the fetch stage and register file, and replaces per-cycle single-step control.

---
 rtl/risc16_pkg.sv | 8 +
 rtl/risc16_sequencer.sv | 77 +++++++
 tb/tb_risc16_sequencer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/risc16_pkg.sv
// risc16_pkg: opcode, state and datapath-select encodings shared by the RiSC-16 control slice
package risc16_pkg;
   typedef enum logic [2:0] {OP_ADD, OP_ADDI, OP_NAND, OP_LUI, OP_SW, OP_LW, OP_BEQ, OP_JALR} opcode_e;
   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;
   localparam logic [1:0] PC_NEXT = 2'd0, PC_BRANCH = 2'd1, PC_REGB = 2'd2;
   localparam logic [1:0] ALU_ADD = 2'd0, ALU_NAND = 2'd1, ALU_CMP = 2'd3;
   localparam logic [1:0] WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC1 = 2'd2, WB_IMM = 2'd3;
endpackage

// File: rtl/risc16_sequencer.sv
// risc16_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control with ready stalls and retire counter
module risc16_sequencer
   import risc16_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       opcode,
   input  logic             alu_eq,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   input  logic             halt_req,
   output logic             imem_req,
   output logic             ir_we,
   output logic             pc_we,
   output logic [1:0]       pc_sel,
   output logic             alu_src,
   output logic [1:0]       alu_op,
   output logic             rf_we,
   output logic [1:0]       wb_sel,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic             retire,
   output logic [CNT_W-1:0] instret,
   output logic [2:0]       state
);
   state_e st, nx;
   logic [CNT_W-1:0] cnt;
   logic en, ex, mem, wb;
   logic is_sw, is_lw, is_beq, is_jalr, is_lui;
   assign is_sw   = opcode == OP_SW;
   assign is_lw   = opcode == OP_LW;
   assign is_beq  = opcode == OP_BEQ;
   assign is_jalr = opcode == OP_JALR;
   assign is_lui  = opcode == OP_LUI;
   always_comb begin
      nx = st;
      case (st)
         S_FETCH:  nx = halt_req ? S_HALT : imem_ready ? S_DECODE : S_FETCH;
         S_DECODE: nx = (is_lui || is_jalr) ? S_WB : S_EXEC;
         S_EXEC:   nx = is_beq ? S_FETCH : (is_sw || is_lw) ? S_MEM : S_WB;
         S_MEM:    nx = !dmem_ready ? S_MEM : is_sw ? S_FETCH : S_WB;
         S_WB:     nx = S_FETCH;
         default:  nx = S_HALT;
      endcase
   end
   // reset forces every output low in the same cycle, even mid-instruction
   assign en  = !reset;
   assign ex  = en && st == S_EXEC;
   assign mem = en && st == S_MEM;
   assign wb  = en && st == S_WB;
   always_comb begin
      imem_req = en && st == S_FETCH && !halt_req;
      ir_we    = imem_req && imem_ready;
      alu_src  = ex && (opcode == OP_ADDI || is_sw || is_lw);
      alu_op   = !ex ? ALU_ADD : opcode == OP_NAND ? ALU_NAND : is_beq ? ALU_CMP : ALU_ADD;
      dmem_req = mem;
      dmem_we  = mem && is_sw;
      rf_we    = wb;
      wb_sel   = !wb ? WB_ALU : is_lw ? WB_MEM : is_jalr ? WB_PC1 : is_lui ? WB_IMM : WB_ALU;
      pc_we    = (ex && is_beq) || (mem && dmem_ready && is_sw) || wb;
      pc_sel   = (ex && is_beq && alu_eq) ? PC_BRANCH : (wb && is_jalr) ? PC_REGB : PC_NEXT;
      retire   = pc_we;
      state    = en ? st : S_FETCH;
      instret  = en ? cnt : '0;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         st  <= S_FETCH;
         cnt <= '0;
      end else begin
         st  <= nx;
         cnt <= cnt + {{(CNT_W-1){1'b0}}, retire};
      end
   end
endmodule

// File: tb/tb_risc16_sequencer.sv
// tb_risc16_sequencer: per-cycle trace model of each instruction compared against two sequencer instances
module tb_risc16_sequencer;
   import risc16_pkg::*;
   typedef struct packed {
      logic       imem_req, ir_we, pc_we;
      logic [1:0] pc_sel;
      logic       alu_src;
      logic [1:0] alu_op;
      logic       rf_we;
      logic [1:0] wb_sel;
      logic       dmem_req, dmem_we, retire;
   } outs_t;
   typedef struct {
      logic [2:0] st;
      logic       ir, dr;
      outs_t      o;
   } step_t;
   logic clk = 0, reset = 1, alu_eq = 0, imem_ready = 0, dmem_ready = 0, halt_req = 0;
   logic [2:0] opcode = 0;
   logic imem_req, ir_we, pc_we, alu_src, rf_we, dmem_req, dmem_we, retire;
   logic [1:0] pc_sel, alu_op, wb_sel;
   logic [15:0] instret;
   logic [2:0] state;
   wire [13:0] obs_s;
   wire [2:0] state_s, instret_s;
   outs_t obs;
   int n_chk = 0, n_fail = 0;
   int unsigned cnt = 0;
   step_t q[$];
   assign obs = {imem_req, ir_we, pc_we, pc_sel, alu_src, alu_op, rf_we, wb_sel, dmem_req, dmem_we, retire};
   always #5 clk = ~clk;
   risc16_sequencer dut (
      .clk(clk), .reset(reset), .opcode(opcode), .alu_eq(alu_eq), .imem_ready(imem_ready),
      .dmem_ready(dmem_ready), .halt_req(halt_req), .imem_req(imem_req), .ir_we(ir_we),
      .pc_we(pc_we), .pc_sel(pc_sel), .alu_src(alu_src), .alu_op(alu_op), .rf_we(rf_we),
      .wb_sel(wb_sel), .dmem_req(dmem_req), .dmem_we(dmem_we), .retire(retire),
      .instret(instret), .state(state)
   );
   // narrow counter copy exercises wrap-around within a short run
   risc16_sequencer #(.CNT_W(3)) dut_s (
      .clk(clk), .reset(reset), .opcode(opcode), .alu_eq(alu_eq), .imem_ready(imem_ready),
      .dmem_ready(dmem_ready), .halt_req(halt_req), .imem_req(obs_s[13]), .ir_we(obs_s[12]),
      .pc_we(obs_s[11]), .pc_sel(obs_s[10:9]), .alu_src(obs_s[8]), .alu_op(obs_s[7:6]),
      .rf_we(obs_s[5]), .wb_sel(obs_s[4:3]), .dmem_req(obs_s[2]), .dmem_we(obs_s[1]),
      .retire(obs_s[0]), .instret(instret_s), .state(state_s)
   );
   task automatic chk(string tag, logic [15:0] o, logic [15:0] e);
      n_chk++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask
   task automatic check_cycle(string tag, logic [2:0] est, outs_t eo);
      chk({tag, ".state"}, 16'(state), 16'(est));
      chk({tag, ".outs"}, 16'(obs), 16'(eo));
      chk({tag, ".instret"}, instret, 16'(cnt));
      chk({tag, ".state_s"}, 16'(state_s), 16'(est));
      chk({tag, ".outs_s"}, 16'(obs_s), 16'(eo));
      chk({tag, ".instret_s"}, 16'(instret_s), 16'(cnt & 7));
   endtask
   function automatic step_t mk(logic [2:0] st, logic ir, logic dr);
      step_t s;
      s.st = st;
      s.ir = ir;
      s.dr = dr;
      s.o = '0;
      return s;
   endfunction
   task automatic build(int op, int iw, int dw, bit eq);
      step_t s;
      q.delete();
      repeat (iw) begin
         s = mk(0, 0, 1'($urandom));
         s.o.imem_req = 1;
         q.push_back(s);
      end
      s = mk(0, 1, 1'($urandom));
      s.o.imem_req = 1;
      s.o.ir_we = 1;
      q.push_back(s);
      q.push_back(mk(1, 1'($urandom), 1'($urandom)));
      if (op != 3 && op != 7) begin
         s = mk(2, 1'($urandom), 1'($urandom));
         s.o.alu_src = (op == 1 || op == 4 || op == 5);
         s.o.alu_op = op == 2 ? 2'd1 : op == 6 ? 2'd3 : 2'd0;
         if (op == 6) begin
            s.o.pc_we = 1;
            s.o.pc_sel = eq ? 2'd1 : 2'd0;
            s.o.retire = 1;
         end
         q.push_back(s);
      end
      if (op == 4 || op == 5) begin
         repeat (dw) begin
            s = mk(3, 1'($urandom), 0);
            s.o.dmem_req = 1;
            s.o.dmem_we = op == 4;
            q.push_back(s);
         end
         s = mk(3, 1'($urandom), 1);
         s.o.dmem_req = 1;
         s.o.dmem_we = op == 4;
         s.o.pc_we = op == 4;
         s.o.retire = op == 4;
         q.push_back(s);
      end
      if (op != 6 && op != 4) begin
         s = mk(4, 1'($urandom), 1'($urandom));
         s.o.rf_we = 1;
         s.o.wb_sel = op == 5 ? 2'd1 : op == 7 ? 2'd2 : op == 3 ? 2'd3 : 2'd0;
         s.o.pc_we = 1;
         s.o.pc_sel = op == 7 ? 2'd2 : 2'd0;
         s.o.retire = 1;
         q.push_back(s);
      end
   endtask
   task automatic run(int op, int iw, int dw, bit eq, int stop, string tag);
      build(op, iw, dw, eq);
      alu_eq = eq;
      foreach (q[i]) begin
         if (int'(q[i].st) == stop) return;
         opcode = q[i].st == 0 ? 3'($urandom) : 3'(op);
         halt_req = q[i].st == 0 ? 1'b0 : 1'($urandom);
         imem_ready = q[i].ir;
         dmem_ready = q[i].dr;
         @(negedge clk);
         check_cycle(tag, q[i].st, q[i].o);
         @(posedge clk);
         #1;
         if (q[i].o.retire) cnt++;
      end
   endtask
   initial begin
      imem_ready = 1;
      dmem_ready = 1;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check_cycle("reset", 0, '0);
      @(posedge clk);
      #1;
      reset = 0;
      run(0, 0, 0, 0, -1, "add");
      run(5, 0, 2, 0, -1, "lw_wait");
      run(6, 0, 0, 1, -1, "beq_taken");
      run(6, 0, 0, 0, -1, "beq_not");
      run(7, 0, 0, 0, -1, "jalr");
      run(4, 1, 3, 0, 3, "sw_rst");
      reset = 1;
      dmem_ready = 1;
      cnt = 0;
      @(negedge clk);
      check_cycle("sw_rst.reset", 0, '0);
      @(posedge clk);
      #1;
      reset = 0;
      run(1, 0, 0, 0, -1, "addi_after_rst");
      for (int i = 0; i < 60; i++)
         run($urandom_range(0, 7), $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom), -1, "rand");
      halt_req = 1;
      imem_ready = 1;
      opcode = 3'($urandom);
      @(negedge clk);
      check_cycle("halt.fetch", 0, '0);
      @(posedge clk);
      #1;
      repeat (4) begin
         halt_req = 1'($urandom);
         imem_ready = 1'($urandom);
         dmem_ready = 1'($urandom);
         alu_eq = 1'($urandom);
         opcode = 3'($urandom);
         @(negedge clk);
         check_cycle("halt", 5, '0);
         @(posedge clk);
         #1;
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
